// File: rtl/rom_reader_pkg.sv
// Shared types and helpers for the ROM stream reader.
// State encoding and FIFO pointer sizing live here.
package rom_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic int unsigned ptr_w(
    input int unsigned depth
  );
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rom_stream_reader_if.sv
// ROM request/response port plus the outgoing valid/ready stream.
// master = reader side, slave = ROM and consumer side.
interface rom_stream_reader_if #(
  parameter int Width = 32,
  parameter int Aw    = 11
);

  logic             rom_cs_o;
  logic [Aw-1:0]    rom_addr_o;
  logic [Width-1:0] rom_rdata_i;
  logic             rom_rvalid_i;

  logic             out_valid_o;
  logic [Width-1:0] out_data_o;
  logic             out_last_o;
  logic             out_ready_i;

  modport master (
    output rom_cs_o,
    output rom_addr_o,
    input  rom_rdata_i,
    input  rom_rvalid_i,
    output out_valid_o,
    output out_data_o,
    output out_last_o,
    input  out_ready_i
  );

  modport slave (
    input  rom_cs_o,
    input  rom_addr_o,
    output rom_rdata_i,
    output rom_rvalid_i,
    input  out_valid_o,
    input  out_data_o,
    input  out_last_o,
    output out_ready_i
  );

endinterface

// File: rtl/rom_reader_fifo.sv
// Small synchronous FIFO buffering ROM words with their last flag.
// Depth must be a power of two so the pointers wrap naturally.
module rom_reader_fifo
  import rom_reader_pkg::*;
#(
  parameter  int Width = 33,
  parameter  int Depth = 4,
  localparam int Pw    = ptr_w(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [Pw:0]      count_o
);

  localparam logic [Pw:0]   CntOne = (Pw+1)'(1);
  localparam logic [Pw:0]   CntMax = (Pw+1)'(Depth);
  localparam logic [Pw-1:0] PtrOne = Pw'(1);

  logic [Width-1:0] r_mem [Depth];
  logic [Pw-1:0]    r_wptr;
  logic [Pw-1:0]    r_rptr;
  logic [Pw:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign empty_o = (r_count == '0);
  assign full_o  = (r_count == CntMax);
  assign count_o = r_count;
  assign rdata_o = r_mem[r_rptr];

  // A pop frees the slot, so push on full is fine when paired with a pop.
  assign w_pop  = pop_i & ~empty_o;
  assign w_push = push_i & (~full_o | w_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wptr] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PtrOne;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PtrOne;
      end
      unique case (1'b1)
        (w_push && !w_pop): r_count <= r_count + CntOne;
        (w_pop && !w_push): r_count <= r_count - CntOne;
        default:            r_count <= r_count;
      endcase
    end
  end

  a_no_overflow: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    !(push_i && full_o && !pop_i)
  );

endmodule

// File: rtl/rom_stream_reader.sv
// Fetches a run of consecutive ROM words and streams them out
// through a credit-checked FIFO with a last marker.
module rom_stream_reader
  import rom_reader_pkg::*;
#(
  parameter int Width     = 32,
  parameter int Depth     = 2048,
  parameter int Aw        = $clog2(Depth),
  parameter int FifoDepth = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [Aw-1:0] base_addr_i,
  input  logic [Aw:0]   len_i,
  output logic          busy_o,
  output logic          done_o,
  rom_stream_reader_if.master bus
);

  localparam int Pw = ptr_w(FifoDepth);

  localparam logic [Aw-1:0] AddrOne = Aw'(1);
  localparam logic [Aw:0]   LenOne  = (Aw+1)'(1);
  localparam logic [Pw+1:0] Cap     = (Pw+2)'(FifoDepth);

  state_e         r_state;
  state_e         w_state_nxt;
  logic [Aw-1:0]  r_addr;
  logic [Aw:0]    r_issue_left;
  logic [Aw:0]    r_recv_left;
  logic           r_inflight;

  logic           w_accept;
  logic           w_cs;
  logic           w_last_issue;
  logic           w_push;
  logic           w_push_last;
  logic           w_pop;
  logic           w_full;
  logic           w_empty;
  logic [Pw:0]    w_count;
  logic [Pw+1:0]  w_credit;
  logic [Width:0] w_head;

  assign w_accept = (r_state == IDLE) && start_i;

  // Pops this cycle are not credited; the check only gets stricter.
  assign w_credit = {1'b0, w_count}
                  + {{(Pw+1){1'b0}}, r_inflight};

  assign w_cs = (r_state == FETCH)
             && (r_issue_left != '0)
             && (w_credit < Cap);

  assign w_last_issue = w_cs && (r_issue_left == LenOne);

  assign w_push      = bus.rom_rvalid_i & r_inflight;
  assign w_push_last = (r_recv_left == LenOne);
  assign w_pop       = bus.out_valid_o & bus.out_ready_i;

  rom_reader_fifo #(
    .Width (Width + 1),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_push),
    .wdata_i ({w_push_last, bus.rom_rdata_i}),
    .pop_i   (w_pop),
    .rdata_o (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (start_i) begin
          w_state_nxt = (len_i == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (w_last_issue) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (w_pop && w_head[Width]) begin
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr       <= '0;
      r_issue_left <= '0;
      r_recv_left  <= '0;
      r_inflight   <= 1'b0;
    end else begin
      r_inflight <= w_cs;
      if (w_accept) begin
        r_addr       <= base_addr_i;
        r_issue_left <= len_i;
        r_recv_left  <= len_i;
      end else begin
        if (w_cs) begin
          r_addr       <= r_addr + AddrOne;
          r_issue_left <= r_issue_left - LenOne;
        end
        if (w_push) begin
          r_recv_left <= r_recv_left - LenOne;
        end
      end
    end
  end

  assign busy_o = (r_state == FETCH) || (r_state == DRAIN);
  assign done_o = (r_state == DONE);

  assign bus.rom_cs_o    = w_cs;
  assign bus.rom_addr_o  = r_addr;
  assign bus.out_valid_o = ~w_empty;
  assign bus.out_data_o  = w_head[Width-1:0];
  assign bus.out_last_o  = w_head[Width] & ~w_empty;

  a_rvalid_expected: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    bus.rom_rvalid_i |-> r_inflight
  );

  a_fifo_room: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    !(w_push && w_full && !w_pop)
  );

endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed bench for rom_stream_reader against a behavioural ROM.
// Each step checks against hand-derived expected values.
module tb_rom_stream_reader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [10:0] base_addr;
  logic [11:0] len;
  logic        busy;
  logic        done;

  rom_stream_reader_if #(.Width(32), .Aw(11)) rif ();

  rom_stream_reader #(
    .Width     (32),
    .Depth     (2048),
    .Aw        (11),
    .FifoDepth (4)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .base_addr_i (base_addr),
    .len_i       (len),
    .busy_o      (busy),
    .done_o      (done),
    .bus         (rif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [10:0] a);
    return {16'hC0DE, 5'b0, a};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rif.rom_rvalid_i <= 1'b0;
      rif.rom_rdata_i  <= '0;
    end else begin
      rif.rom_rvalid_i <= rif.rom_cs_o;
      rif.rom_rdata_i  <= rif.rom_cs_o ? rom_word(rif.rom_addr_o)
                                       : 32'hDEAD_BEEF;
    end
  end

  int n_pass;
  int n_total;

  logic [10:0] q_addr [$];
  logic [31:0] q_data [$];
  logic        q_last [$];
  int          n_done;
  bit          timed_out;
  int          n_cs;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_xfer(input logic [10:0] b, input logic [11:0] l);
    base_addr = b;
    len       = l;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic collect(input int max_cyc, input bit rnd);
    q_addr.delete();
    q_data.delete();
    q_last.delete();
    n_done    = 0;
    timed_out = 1'b1;
    for (int c = 0; c < max_cyc; c++) begin
      if (rnd) rif.out_ready_i = 1'($urandom_range(0, 1));
      #1;
      if (rif.rom_cs_o) q_addr.push_back(rif.rom_addr_o);
      if (rif.out_valid_o && rif.out_ready_i) begin
        q_data.push_back(rif.out_data_o);
        q_last.push_back(rif.out_last_o);
      end
      if (done) begin
        n_done++;
        timed_out = 1'b0;
        break;
      end
      tick();
    end
  endtask

  task automatic chk_run(input string tag,
                         input logic [10:0] b,
                         input int n);
    chk({tag, "_timeout"}, timed_out, 0);
    chk({tag, "_beats"}, q_data.size(), n);
    for (int i = 0; i < n && i < q_data.size(); i++) begin
      chk({tag, "_data"}, q_data[i], rom_word(b + 11'(i)));
      chk({tag, "_last"}, q_last[i], (i == n - 1));
    end
    chk({tag, "_done_cnt"}, n_done, 1);
  endtask

  initial begin
    logic [10:0] exp_wrap [4];
    n_pass  = 0;
    n_total = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    len       = '0;
    rif.out_ready_i = 1'b1;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cs", rif.rom_cs_o, 0);
    chk("rst_addr", rif.rom_addr_o, 0);
    chk("rst_valid", rif.out_valid_o, 0);
    chk("rst_data", rif.out_data_o, 0);
    chk("rst_last", rif.out_last_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 1: base 0x010 len 3, ready high
    start_xfer(11'h010, 12'd3);
    chk("t1_cs0", rif.rom_cs_o, 1);
    chk("t1_addr0", rif.rom_addr_o, 11'h010);
    chk("t1_busy", busy, 1);
    chk("t1_valid0", rif.out_valid_o, 0);
    tick();
    chk("t1_cs1", rif.rom_cs_o, 1);
    chk("t1_addr1", rif.rom_addr_o, 11'h011);
    chk("t1_valid1", rif.out_valid_o, 0);
    tick();
    chk("t1_cs2", rif.rom_cs_o, 1);
    chk("t1_addr2", rif.rom_addr_o, 11'h012);
    chk("t1_valid2", rif.out_valid_o, 1);
    chk("t1_beat0", rif.out_data_o, 32'hC0DE_0010);
    chk("t1_last0", rif.out_last_o, 0);
    tick();
    chk("t1_cs3", rif.rom_cs_o, 0);
    chk("t1_beat1", rif.out_data_o, 32'hC0DE_0011);
    chk("t1_last1", rif.out_last_o, 0);
    tick();
    chk("t1_beat2", rif.out_data_o, 32'hC0DE_0012);
    chk("t1_last2", rif.out_last_o, 1);
    chk("t1_busy_drain", busy, 1);
    chk("t1_done_early", done, 0);
    tick();
    chk("t1_done", done, 1);
    chk("t1_busy_done", busy, 0);
    chk("t1_valid_end", rif.out_valid_o, 0);
    tick();
    chk("t1_done_gone", done, 0);

    // 2: zero length
    start_xfer(11'h055, 12'd0);
    chk("t2_cs", rif.rom_cs_o, 0);
    chk("t2_done", done, 1);
    chk("t2_busy", busy, 0);
    tick();
    chk("t2_done_gone", done, 0);
    chk("t2_cs_after", rif.rom_cs_o, 0);

    // 3: address wrap
    start_xfer(11'h7FE, 12'd4);
    collect(40, 1'b0);
    exp_wrap[0] = 11'h7FE;
    exp_wrap[1] = 11'h7FF;
    exp_wrap[2] = 11'h000;
    exp_wrap[3] = 11'h001;
    chk("t3_naddr", q_addr.size(), 4);
    for (int i = 0; i < 4 && i < q_addr.size(); i++)
      chk("t3_addr", q_addr[i], exp_wrap[i]);
    chk_run("t3", 11'h7FE, 4);
    tick();

    // 4: backpressure; a mid-run start must be ignored
    rif.out_ready_i = 1'b0;
    start_xfer(11'h200, 12'd16);
    n_cs = 0;
    for (int c = 0; c < 20; c++) begin
      if (rif.rom_cs_o) n_cs++;
      start = (c == 5);
      if (c == 5) begin
        base_addr = 11'h000;
        len       = 12'd1;
      end
      tick();
    end
    start = 1'b0;
    chk("t4_issued", n_cs, 4);
    chk("t4_cs_stall", rif.rom_cs_o, 0);
    chk("t4_head", rif.out_data_o, 32'hC0DE_0200);
    chk("t4_busy", busy, 1);
    rif.out_ready_i = 1'b1;
    collect(200, 1'b0);
    chk_run("t4", 11'h200, 16);
    tick();

    // 5: random backpressure, len 64
    start_xfer(11'h300, 12'd64);
    collect(2000, 1'b1);
    chk_run("t5", 11'h300, 64);
    rif.out_ready_i = 1'b1;
    tick();

    // 6: reset in the middle of FETCH
    rif.out_ready_i = 1'b0;
    start_xfer(11'h400, 12'd32);
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_cs", rif.rom_cs_o, 0);
    chk("t6_rst_valid", rif.out_valid_o, 0);
    chk("t6_rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("t6_idle_done", done, 0);
    chk("t6_idle_valid", rif.out_valid_o, 0);
    rif.out_ready_i = 1'b1;
    start_xfer(11'h100, 12'd2);
    collect(50, 1'b0);
    chk("t6_naddr", q_addr.size(), 2);
    if (q_addr.size() == 2) begin
      chk("t6_addr0", q_addr[0], 11'h100);
      chk("t6_addr1", q_addr[1], 11'h101);
    end
    chk_run("t6", 11'h100, 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
